uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter APPEND_CRLF, default 1, which when 1 appends bytes 0x0D then 0x0A after every message.
REQ-002 The block SHALL have parameter MAX_LEN, default 255, giving the maximum payload bytes per message (range 1..255).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high, with ports: clk  input  1  clock; rst  input  1  sync active-high reset.
REQ-004 The block SHALL have port i_req  input  4  per-requester message request/byte-valid.
REQ-005 The block SHALL have port i_data  input  32  requester k byte at [8k+7:8k].
REQ-006 The block SHALL have port i_last  input  4  per-requester flag marking the current byte as the final payload byte.
REQ-007 The block SHALL have port o_ack  output  4  one-cycle pulse when requester k's byte is issued.
REQ-008 The block SHALL have port o_grant  output  4  one-hot owner of the TX path, all zero when idle.
REQ-009 The block SHALL have port o_abort  output  1  one-cycle pulse on an aborted or truncated message.
REQ-010 The block SHALL have port o_tx_stb  output  1  byte strobe to the UART TX front end.
REQ-011 The block SHALL have port o_tx_data  output  8  byte accompanying o_tx_stb.
REQ-012 The block SHALL have port i_tx_busy  input  1  UART TX front-end busy; it rises the cycle after an accepted strobe.
REQ-013 The block SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, STB, WAIT, CR and LF, with a 2-bit nxt register selecting SEND, CR, LF or IDLE after WAIT.
REQ-015 In IDLE with i_req nonzero, the FSM SHALL pick the first set bit searching from ptr upward modulo 4, load o_grant one-hot, clear the byte counter cnt, and enter SEND the next cycle.
REQ-016 In SEND with i_tx_busy=0 and i_req[g]=1, the FSM SHALL register o_tx_stb=1, o_tx_data=i_data[g] and o_ack[g]=1 for exactly the next cycle, increment cnt, and enter STB.
REQ-017 In SEND with i_tx_busy=1, the FSM SHALL hold with no strobe and no ack.
REQ-018 At issue, nxt SHALL be SEND, unless i_last[g]=1 or cnt+1=MAX_LEN, in which case nxt SHALL be CR if APPEND_CRLF=1, else IDLE.
REQ-019 A truncation (cnt+1=MAX_LEN with i_last[g]=0) SHALL pulse o_abort with the strobe.
REQ-020 STB SHALL last one cycle and go to WAIT, and o_tx_stb SHALL never be high on two consecutive cycles.
REQ-021 WAIT SHALL stay until i_tx_busy=0, then move to nxt.
REQ-022 In SEND, i_req[g]=0 (requester withdrew mid-message) SHALL pulse o_abort for one cycle and go to CR if APPEND_CRLF=1, else IDLE, issuing no byte.
REQ-023 CR with i_tx_busy=0 SHALL strobe 0x0D with no o_ack and set nxt=LF; LF with i_tx_busy=0 SHALL strobe 0x0A and set nxt=IDLE; both go through STB and WAIT.
REQ-024 On entry to IDLE, o_grant SHALL clear and ptr SHALL become (g+1) mod 4.
REQ-025 Requests arriving during a message SHALL be held off until IDLE, and non-granted requesters SHALL never see o_ack.
REQ-026 Arbitration SHALL add one cycle: i_req rising at cycle T with i_tx_busy=0 gives o_tx_stb at T+2.
REQ-027 o_tx_data SHALL hold its last value when o_tx_stb=0, and o_ack SHALL be zero unless o_tx_stb=1 carries payload.
REQ-028 A requester SHALL present its next byte in the cycle after o_ack; the block samples i_data only in SEND.

Reset
REQ-029 While rst=1, the block SHALL force state IDLE, ptr=0, cnt=0, nxt=IDLE, and o_ack, o_grant, o_abort, o_tx_stb, o_tx_data and o_busy all 0.
REQ-030 Reset mid-message SHALL drop the message with no CR/LF and no o_abort, and the first post-reset arbitration SHALL start from requester 0.

Verification
REQ-031 Single message: req0 sends 0x41,0x42 (last), with busy held 3 cycles per byte -> tx sequence 41,42,0D,0A; o_ack[0] pulses twice; o_grant=0001 throughout, then 0000.
REQ-032 Round robin: i_req=1111 held with 1-byte messages -> grant order 0,1,2,3,0; with i_req=0101 after serving 0, the next grant is 2.
REQ-033 Abort: req2 drops i_req after 1 of 3 bytes -> o_abort pulse, tx 0D,0A follow, and grant is released.
REQ-034 Truncation: MAX_LEN=4, req1 never asserts i_last -> 4 payload bytes, o_abort with the 4th strobe, then 0D,0A.
REQ-035 Busy stall: i_tx_busy forced high 20 cycles in SEND -> no strobe or ack; strobe occurs the cycle after busy falls; strobes are never back-to-back.
REQ-036 Reset mid-message (APPEND_CRLF=0 run too): rst during WAIT -> all outputs 0 the next cycle, no CR/LF; with i_req=1000 after reset the grant goes to 3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one UART TX front end,
// one whole message at a time, optionally terminating each message with CR/LF.
module uart_tx_arbiter #(
    parameter int APPEND_CRLF = 1,
    parameter int MAX_LEN     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_data,
    input  logic [3:0]  i_last,
    output logic [3:0]  o_ack,
    output logic [3:0]  o_grant,
    output logic        o_abort,
    output logic        o_tx_stb,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_busy,
    output logic        o_busy
);
    typedef enum logic [2:0] {IDLE, SEND, STB, WAIT, CR, LF} state_t;
    typedef enum logic [1:0] {NX_IDLE, NX_SEND, NX_CR, NX_LF} nxt_t;

    state_t          state;
    nxt_t            nxt;
    logic [1:0]      ptr;
    logic [1:0]      gidx;
    logic [1:0]      pick;
    logic            found;
    logic [7:0]      cnt;
    logic [3:0][7:0] req_byte;
    logic            at_max;

    assign req_byte = i_data;
    assign at_max   = (cnt == 8'(MAX_LEN - 1));
    assign o_busy   = (state != IDLE);

    // First requesting index at or above ptr, wrapping modulo 4.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] c;
            c = ptr + 2'(i);
            if (!found && i_req[c]) begin
                pick  = c;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            nxt       <= NX_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            cnt       <= '0;
            o_ack     <= '0;
            o_grant   <= '0;
            o_abort   <= 1'b0;
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
        end else begin
            o_tx_stb <= 1'b0;
            o_ack    <= '0;
            o_abort  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        o_grant <= 4'(1) << pick;
                        gidx    <= pick;
                        cnt     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!i_req[gidx]) begin
                        // Requester withdrew mid-message: close it out without a byte.
                        o_abort <= 1'b1;
                        if (APPEND_CRLF != 0) begin
                            state <= CR;
                        end else begin
                            state   <= IDLE;
                            o_grant <= '0;
                            ptr     <= gidx + 2'd1;
                        end
                    end else if (!i_tx_busy) begin
                        o_tx_stb  <= 1'b1;
                        o_tx_data <= req_byte[gidx];
                        o_ack     <= 4'(1) << gidx;
                        cnt       <= cnt + 8'd1;
                        state     <= STB;
                        if (i_last[gidx] || at_max) begin
                            nxt     <= (APPEND_CRLF != 0) ? NX_CR : NX_IDLE;
                            o_abort <= !i_last[gidx];
                        end else begin
                            nxt <= NX_SEND;
                        end
                    end
                end
                STB: state <= WAIT;
                WAIT: begin
                    if (!i_tx_busy) begin
                        case (nxt)
                            NX_SEND: state <= SEND;
                            NX_CR:   state <= CR;
                            NX_LF:   state <= LF;
                            default: begin
                                state   <= IDLE;
                                o_grant <= '0;
                                ptr     <= gidx + 2'd1;
                            end
                        endcase
                    end
                end
                CR: begin
                    if (!i_tx_busy) begin
                        o_tx_stb  <= 1'b1;
                        o_tx_data <= 8'h0D;
                        nxt       <= NX_LF;
                        state     <= STB;
                    end
                end
                LF: begin
                    if (!i_tx_busy) begin
                        o_tx_stb  <= 1'b1;
                        o_tx_data <= 8'h0A;
                        nxt       <= NX_IDLE;
                        state     <= STB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: three builds (default, MAX_LEN=4,
// APPEND_CRLF=0) share requester stimulus; each has its own busy model.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req, last;
    logic [31:0] data;
    logic        busy_in [3];
    logic [3:0]  ack [3];
    logic [3:0]  grant [3];
    logic        abort [3], stb [3], obusy [3];
    logic [7:0]  txd [3];

    uart_tx_arbiter u0 (
        .clk(clk), .rst(rst), .i_req(req), .i_data(data), .i_last(last),
        .o_ack(ack[0]), .o_grant(grant[0]), .o_abort(abort[0]), .o_tx_stb(stb[0]),
        .o_tx_data(txd[0]), .i_tx_busy(busy_in[0]), .o_busy(obusy[0]));
    uart_tx_arbiter #(.MAX_LEN(4)) u1 (
        .clk(clk), .rst(rst), .i_req(req), .i_data(data), .i_last(last),
        .o_ack(ack[1]), .o_grant(grant[1]), .o_abort(abort[1]), .o_tx_stb(stb[1]),
        .o_tx_data(txd[1]), .i_tx_busy(busy_in[1]), .o_busy(obusy[1]));
    uart_tx_arbiter #(.APPEND_CRLF(0)) u2 (
        .clk(clk), .rst(rst), .i_req(req), .i_data(data), .i_last(last),
        .o_ack(ack[2]), .o_grant(grant[2]), .o_abort(abort[2]), .o_tx_stb(stb[2]),
        .o_tx_data(txd[2]), .i_tx_busy(busy_in[2]), .o_busy(obusy[2]));

    // Requester model: per-requester byte list, per-byte last flags, withdraw point.
    logic [7:0] mbuf [4][8];
    logic [7:0] mlst [4];
    int         mlen [4], mpos [4], mdrop [4];
    int         bcnt [3];
    logic       force_busy;

    int         sel, cyc, first_stb, n_assert, n_fail;
    int         n_ack, n_abort, n_abort_stb, n_b2b, n_badack, n_hold;
    logic [7:0] tx_q [$];
    logic [3:0] gr_q [$];
    logic       prev_stb, last_stb;
    logic [7:0] prev_data;
    logic [3:0] prev_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req[k]          = (mpos[k] < mlen[k]) && (mpos[k] < mdrop[k]);
            data[8*k +: 8]  = mbuf[k][mpos[k] & 7];
            last[k]         = mlst[k][mpos[k] & 7];
        end
        for (int d = 0; d < 3; d++) busy_in[d] = force_busy || (bcnt[d] != 0);
    endtask

    task automatic load(input int k, input int n, input logic [63:0] b,
                        input logic [7:0] l, input int drop);
        for (int i = 0; i < 8; i++) mbuf[k][i] = b[8*i +: 8];
        mlst[k] = l; mlen[k] = n; mpos[k] = 0; mdrop[k] = drop;
        drive();
    endtask

    task automatic clear_models();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) mbuf[k][i] = 8'h00;
            mlst[k] = 8'h00; mlen[k] = 0; mpos[k] = 0; mdrop[k] = 0;
        end
        for (int d = 0; d < 3; d++) bcnt[d] = 0;
        force_busy = 1'b0;
        drive();
    endtask

    task automatic clr();
        tx_q.delete(); gr_q.delete();
        n_ack = 0; n_abort = 0; n_abort_stb = 0; n_b2b = 0; n_badack = 0; n_hold = 0;
        first_stb = -1;
    endtask

    // One clock: sample the selected DUT, advance requesters on ack, update busy models.
    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        last_stb = stb[sel];
        if (stb[sel]) begin
            tx_q.push_back(txd[sel]);
            if (first_stb < 0) first_stb = cyc;
            if (prev_stb) n_b2b++;
            if (abort[sel]) n_abort_stb++;
        end else if (!rst && txd[sel] !== prev_data) begin
            n_hold++;
        end
        if (abort[sel]) n_abort++;
        if (ack[sel] != 4'b0) begin
            n_ack++;
            if (!stb[sel] || (ack[sel] & ~grant[sel]) != 4'b0) n_badack++;
        end
        if (grant[sel] != 4'b0 && grant[sel] != prev_grant) gr_q.push_back(grant[sel]);
        prev_stb = stb[sel]; prev_data = txd[sel]; prev_grant = grant[sel];
        for (int k = 0; k < 4; k++) if (ack[sel][k]) mpos[k]++;
        for (int d = 0; d < 3; d++) begin
            if (stb[d]) bcnt[d] = 3;
            else if (bcnt[d] > 0) bcnt[d]--;
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_models();
        tick(); tick();
        rst = 1'b0;
        clr();
    endtask

    task automatic wait_quiet(input string tag);
        int q = 0;
        for (int i = 0; i < 2000 && q < 3; i++) begin
            tick();
            if (!obusy[sel] && req == 4'b0) q++; else q = 0;
        end
        chk($sformatf("%s_done", tag), 32'(q), 32'd3);
    endtask

    task automatic chk_tx(input string tag, input int n, input logic [127:0] exp);
        chk($sformatf("%s_txlen", tag), 32'(tx_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < tx_q.size()) chk($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp[8*i +: 8]));
    endtask

    task automatic chk_gr(input string tag, input int n, input logic [31:0] exp);
        chk($sformatf("%s_grlen", tag), 32'(gr_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < gr_q.size()) chk($sformatf("%s_gr%0d", tag, i), 32'(gr_q[i]), 32'(exp[4*i +: 4]));
    endtask

    task automatic chk_mon(input string tag);
        chk($sformatf("%s_b2b", tag), 32'(n_b2b), 32'd0);
        chk($sformatf("%s_badack", tag), 32'(n_badack), 32'd0);
        chk($sformatf("%s_hold", tag), 32'(n_hold), 32'd0);
        chk($sformatf("%s_grant_end", tag), 32'(grant[sel]), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_grant%0d", tag, d), 32'(grant[d]), 32'd0);
            chk($sformatf("%s_ack%0d", tag, d), 32'(ack[d]), 32'd0);
            chk($sformatf("%s_stb%0d", tag, d), 32'(stb[d]), 32'd0);
            chk($sformatf("%s_abort%0d", tag, d), 32'(abort[d]), 32'd0);
            chk($sformatf("%s_busy%0d", tag, d), 32'(obusy[d]), 32'd0);
            chk($sformatf("%s_data%0d", tag, d), 32'(txd[d]), 32'd0);
        end
    endtask

    initial begin
        int t0;
        n_assert = 0; n_fail = 0; cyc = 0; sel = 0;
        prev_stb = 1'b0; prev_data = 8'h00; prev_grant = 4'h0;
        clr();

        // Reset state
        do_reset();
        chk_zero("reset");

        // Single message with CR/LF and arbitration latency
        sel = 0;
        t0 = cyc;
        load(0, 2, 64'h4241, 8'b10, 99);
        wait_quiet("single");
        chk("single_latency", 32'(first_stb - t0), 32'd2);
        chk_tx("single", 4, 128'h0A0D4241);
        chk("single_acks", 32'(n_ack), 32'd2);
        chk("single_abort", 32'(n_abort), 32'd0);
        chk_gr("single", 1, 32'h1);
        chk_mon("single");

        // Round robin with all four requesting
        do_reset();
        load(0, 2, 64'hA1A0, 8'b11, 99);
        load(1, 1, 64'hB0, 8'b1, 99);
        load(2, 1, 64'hC0, 8'b1, 99);
        load(3, 1, 64'hD0, 8'b1, 99);
        wait_quiet("rr");
        chk_gr("rr", 5, 32'h18421);
        chk_tx("rr", 15, 128'h0A0DA10A0DD00A0DC00A0DB00A0DA0);
        chk_mon("rr");

        do_reset();
        load(0, 1, 64'h10, 8'b1, 99);
        load(2, 1, 64'h12, 8'b1, 99);
        wait_quiet("rr2");
        chk_gr("rr2", 2, 32'h41);

        // Requester 2 withdraws after its first byte
        do_reset();
        load(2, 3, 64'h333231, 8'b100, 1);
        wait_quiet("abort");
        chk_tx("abort", 3, 128'h0A0D31);
        chk("abort_cnt", 32'(n_abort), 32'd1);
        chk("abort_with_stb", 32'(n_abort_stb), 32'd0);
        chk("abort_acks", 32'(n_ack), 32'd1);
        chk_gr("abort", 1, 32'h4);
        chk_mon("abort");

        // Truncation at MAX_LEN=4
        sel = 1;
        do_reset();
        load(1, 4, 64'h44332211, 8'h00, 99);
        wait_quiet("trunc");
        chk_tx("trunc", 6, 128'h0A0D44332211);
        chk("trunc_acks", 32'(n_ack), 32'd4);
        chk("trunc_abort", 32'(n_abort), 32'd1);
        chk("trunc_abort_stb", 32'(n_abort_stb), 32'd1);
        chk_mon("trunc");

        // Busy stall while in SEND
        sel = 0;
        do_reset();
        force_busy = 1'b1;
        load(0, 1, 64'h77, 8'b1, 99);
        repeat (20) tick();
        chk("stall_no_tx", 32'(tx_q.size()), 32'd0);
        chk("stall_no_ack", 32'(n_ack), 32'd0);
        force_busy = 1'b0;
        drive();
        tick();
        chk("stall_stb_after", 32'(last_stb), 32'd1);
        wait_quiet("stall");
        chk_tx("stall", 3, 128'h0A0D77);
        chk_mon("stall");

        // No CR/LF build, then reset mid-message
        sel = 2;
        do_reset();
        load(0, 1, 64'h55, 8'b1, 99);
        wait_quiet("nocrlf");
        chk_tx("nocrlf", 1, 128'h55);
        chk_gr("nocrlf", 1, 32'h1);
        clr();
        load(2, 3, 64'h656463, 8'b100, 99);
        for (int i = 0; i < 20 && n_ack == 0; i++) tick();
        chk("mid_first_ack", 32'(n_ack), 32'd1);
        tick();
        rst = 1'b1;
        clear_models();
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        clr();
        repeat (10) tick();
        chk("midrst_no_tx", 32'(tx_q.size()), 32'd0);
        chk("midrst_no_abort", 32'(n_abort), 32'd0);
        load(0, 1, 64'h70, 8'b1, 99);
        load(3, 1, 64'h73, 8'b1, 99);
        wait_quiet("postrst");
        chk_gr("postrst", 2, 32'h81);
        chk_tx("postrst", 2, 128'h7370);
        chk_mon("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
